// File: rtl/mac_pkg.sv
// Shared definitions for the MAC lane array: window state encoding and parameter defaults.
package mac_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_OUT_W  = 16;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } mac_state_t;

endpackage

// File: rtl/mac_dot.sv
// Combinational LANES-wide signed dot product of packed w and x, sign-extended to ACC_W.
module mac_dot
  import mac_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [LANES*DATA_W-1:0] w,
  input  logic [LANES*DATA_W-1:0] x,
  output logic [ACC_W-1:0]        beat_sum
);

  logic signed [DATA_W-1:0]   w_wi;
  logic signed [DATA_W-1:0]   w_xi;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_sum;

  always_comb begin
    w_sum  = '0;
    w_wi   = '0;
    w_xi   = '0;
    w_prod = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_wi   = w[i*DATA_W +: DATA_W];
      w_xi   = x[i*DATA_W +: DATA_W];
      w_prod = w_wi * w_xi;
      w_sum  = w_sum + ACC_W'(w_prod);
    end
  end

  assign beat_sum = w_sum;

endmodule

// File: rtl/mac_lane_array.sv
// Windowed multi-lane MAC with one-deep result register and valid/ready handshakes.
// Optional build macro MAC_SAT_EN: clamp the narrowed result and report clipping on ovf.
module mac_lane_array
  import mac_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [LANES*DATA_W-1:0] w,
  input  logic [LANES*DATA_W-1:0] x,
  input  logic [OUT_W-1:0]        psum_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        psum_out,
  output logic [CNT_W-1:0]        out_beats,
  output logic                    ovf
);

  mac_state_t              r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic [OUT_W-1:0]        r_psum;
  logic [CNT_W-1:0]        r_beats;
  logic                    r_ovf;

  logic [ACC_W-1:0]        w_beat_raw;
  logic signed [ACC_W-1:0] w_beat_sum;
  logic signed [OUT_W-1:0] w_psum_in_s;
  logic signed [ACC_W-1:0] w_psum_ext;
  logic signed [ACC_W-1:0] w_final;
  logic [OUT_W-1:0]        w_narrow;
  logic                    w_clip;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic                    w_accept;
  logic                    w_accept_last;

  mac_dot #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_dot (
    .w       (w),
    .x       (x),
    .beat_sum(w_beat_raw)
  );

  assign w_beat_sum    = w_beat_raw;
  assign out_valid     = (r_state == FULL);
  assign in_ready      = !out_valid || out_ready;
  assign w_accept      = in_valid && in_ready;
  assign w_accept_last = w_accept && in_last;

  assign w_psum_in_s = psum_in;
  assign w_psum_ext  = ACC_W'(w_psum_in_s);
  assign w_final     = r_acc + w_beat_sum + w_psum_ext;
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    w_narrow = w_final[OUT_W-1:0];
    w_clip   = 1'b0;
    if (w_final > MAXV) begin
      w_narrow = MAXV[OUT_W-1:0];
      w_clip   = 1'b1;
    end else if (w_final < MINV) begin
      w_narrow = MINV[OUT_W-1:0];
      w_clip   = 1'b1;
    end
  end
`else
  assign w_narrow = w_final[OUT_W-1:0];
  assign w_clip   = 1'b0;
`endif

  // Accumulator/counter follow accepted beats in either state; the FSM only owns the result slot.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= EMPTY;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_psum  <= '0;
      r_beats <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_acc <= r_acc + w_beat_sum;
        r_cnt <= w_cnt_inc;
      end

      case (r_state)
        EMPTY: begin
          if (w_accept_last) begin
            r_psum  <= w_narrow;
            r_beats <= w_cnt_inc;
            r_ovf   <= w_clip;
            r_state <= FULL;
          end
        end
        FULL: begin
          if (w_accept_last) begin
            r_psum  <= w_narrow;
            r_beats <= w_cnt_inc;
            r_ovf   <= w_clip;
            r_state <= FULL;
          end else if (out_ready) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign psum_out  = r_psum;
  assign out_beats = r_beats;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_mac_lane_array.sv
// Scoreboard bench for mac_lane_array (LANES=4, DATA_W=8, ACC_W=24, OUT_W=16, CNT_W=8).
module tb_mac_lane_array;

  logic        clk = 1'b0;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [31:0] w;
  logic [31:0] x;
  logic [15:0] psum_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] psum_out;
  logic [7:0]  out_beats;
  logic        ovf;

  typedef struct {
    longint psum;
    longint beats;
    bit     ovf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_ready   = 1'b0;
  bit   spacing_chk = 1'b0;
  bit   have_prev   = 1'b0;
  time  prev_pop;

  always #5 clk = ~clk;

  mac_lane_array #(
    .LANES (4),
    .DATA_W(8),
    .ACC_W (24),
    .OUT_W (16),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .w        (w),
    .x        (x),
    .psum_in  (psum_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .psum_out (psum_out),
    .out_beats(out_beats),
    .ovf      (ovf)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic exp_t mk(input longint p, input longint b, input bit o);
    exp_t e;
    e.psum  = p;
    e.beats = b;
    e.ovf   = o;
    return e;
  endfunction

  // Monitor: a result is consumed at the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (!clear && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("psum_out", longint'($signed(psum_out)), e.psum);
        chk("out_beats", longint'(out_beats), e.beats);
        chk("ovf", longint'(ovf), longint'(e.ovf));
        if (spacing_chk) begin
          if (have_prev) chk("result_spacing_ns", longint'($time - prev_pop), 20);
          have_prev = 1'b1;
          prev_pop  = $time;
        end
      end
    end
  end

  task automatic beat(input logic [31:0] wv, input logic [31:0] xv, input logic last, input int ps);
    int waited;
    in_valid = 1'b1;
    w        = wv;
    x        = xv;
    in_last  = last;
    psum_in  = 16'(ps);
    waited   = 0;
    forever begin
      @(negedge clk);
      if (chk_ready) chk("in_ready_streaming", longint'(in_ready), 1);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      waited++;
      if (waited > 50) begin
        chk("beat_accept_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int wait_cyc;
    clear     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    w         = '0;
    x         = '0;
    psum_in   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_psum_out", longint'(psum_out), 0);
    chk("reset_out_beats", longint'(out_beats), 0);
    chk("reset_ovf", longint'(ovf), 0);
    chk("reset_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    // Single-beat window: 5+12+21+32+30 = 100, visible one cycle later.
    q.push_back(mk(100, 1, 1'b0));
    beat(pack(1, 2, 3, 4), pack(5, 6, 7, 8), 1'b1, 30);
    chk("latency_out_valid", longint'(out_valid), 1);
    idle(2);

    // 3 x 65536 = 196608: clamps in saturating builds, wraps to 0 otherwise.
`ifdef MAC_SAT_EN
    q.push_back(mk(32767, 3, 1'b1));
`else
    q.push_back(mk(0, 3, 1'b0));
`endif
    beat(pack(-128, -128, -128, -128), pack(-128, -128, -128, -128), 1'b0, 0);
    beat(pack(-128, -128, -128, -128), pack(-128, -128, -128, -128), 1'b0, 0);
    beat(pack(-128, -128, -128, -128), pack(-128, -128, -128, -128), 1'b1, 0);
    idle(2);

    // Mixed signs: -6, -40, then psum_in -100 -> -146.
    q.push_back(mk(-146, 3, 1'b0));
    beat(pack(-1, 2, -3, 4), pack(5, -6, 7, 8), 1'b0, 0);
    beat(pack(10, 10, 10, 10), pack(-1, -1, -1, -1), 1'b0, 0);
    beat(pack(0, 0, 0, 0), pack(0, 0, 0, 0), 1'b1, -100);
    idle(2);

    // Negative overflow: -65024 - 32768 = -97792.
`ifdef MAC_SAT_EN
    q.push_back(mk(-32768, 1, 1'b1));
`else
    q.push_back(mk(-32256, 1, 1'b0));
`endif
    beat(pack(-128, -128, -128, -128), pack(127, 127, 127, 127), 1'b1, -32768);
    idle(2);

    // Backpressure: result held while out_ready=0, non-last beats blocked.
    out_ready = 1'b0;
    q.push_back(mk(4, 1, 1'b0));
    beat(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b1, 0);
    chk("stall_out_valid", longint'(out_valid), 1);
    in_valid = 1'b1;
    in_last  = 1'b0;
    w        = pack(5, 5, 5, 5);
    x        = pack(5, 5, 5, 5);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", longint'(in_ready), 0);
      chk("stall_psum_hold", longint'($signed(psum_out)), 4);
      chk("stall_beats_hold", longint'(out_beats), 1);
    end
    @(posedge clk);
    #1;
    q.push_back(mk(8, 1, 1'b0));
    out_ready = 1'b1;
    in_last   = 1'b1;
    w         = pack(2, 2, 2, 2);
    x         = pack(1, 1, 1, 1);
    psum_in   = 16'd0;
    @(negedge clk);
    chk("release_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("no_bubble_out_valid", longint'(out_valid), 1);
    idle(2);

    // Clear mid-window discards the partial sum and overrides a concurrent beat.
    beat(pack(5, 5, 5, 5), pack(5, 5, 5, 5), 1'b0, 0);
    beat(pack(5, 5, 5, 5), pack(5, 5, 5, 5), 1'b0, 0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    w        = pack(3, 3, 3, 3);
    x        = pack(3, 3, 3, 3);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clear_out_valid", longint'(out_valid), 0);
    chk("clear_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    q.push_back(mk(11, 1, 1'b0));
    beat(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b1, 7);
    idle(2);

    // Back-to-back 2-beat windows at full rate.
    spacing_chk = 1'b1;
    have_prev   = 1'b0;
    chk_ready   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      beat(pack(k, k, k, k), pack(1, 1, 1, 1), 1'b0, 0);
      q.push_back(mk(4 * k + 4, 2, 1'b0));
      beat(pack(1, 1, 1, 1), pack(1, 1, 1, 1), 1'b1, 0);
    end
    chk_ready = 1'b0;
    idle(2);
    spacing_chk = 1'b0;

    // Beat counter saturation: 260 beats report 255.
    for (int i = 0; i < 259; i++) beat('0, '0, 1'b0, 0);
    q.push_back(mk(5, 255, 1'b0));
    beat('0, '0, 1'b1, 5);
    idle(2);

    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    chk("scoreboard_drained", longint'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_lane_array.md
MAC_LANE_ARRAY -- requirements
Module: mac_lane_array

Interface
REQ-001 Parameter LANES, default 4, number of parallel weight/activation multiplier lanes (1..16).
REQ-002 Parameter DATA_W, default 8, signed width of each w and x element.
REQ-003 Parameter ACC_W, default 24, signed internal accumulator width; SHALL be >= 2*DATA_W+clog2(LANES)+1.
REQ-004 Parameter OUT_W, default 16, signed width of psum_in and psum_out; SHALL be <= ACC_W.
REQ-005 Parameter CNT_W, default 8, width of the window beat counter.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 clear  input  1  reset, synchronous, active-high.
REQ-008 in_valid  input  1  a beat is present on w, x, in_last, psum_in.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 in_last  input  1  accepted beat closes the current accumulation window.
REQ-011 w  input  LANES*DATA_W  packed signed weights, lane i at bits [i*DATA_W +: DATA_W].
REQ-012 x  input  LANES*DATA_W  packed signed activations, same packing as w.
REQ-013 psum_in  input  OUT_W  signed upstream partial sum, sampled only on an accepted last beat.
REQ-014 out_valid  output  1  psum_out/out_beats/ovf hold a result.
REQ-015 out_ready  input  1  downstream takes the result this cycle.
REQ-016 psum_out  output  OUT_W  signed window result.
REQ-017 out_beats  output  CNT_W  beats in the window, saturating at all-ones.
REQ-018 ovf  output  1  result clipped during narrowing (MAC_SAT_EN builds only).

Function
REQ-019 Accepted beat SHALL mean in_valid && in_ready in the same cycle; no other input causes accumulation.
REQ-020 beat_sum SHALL be the sign-extended sum over all lanes of signed w_i*x_i, computed combinationally at ACC_W.
REQ-021 Accepted non-last beat: acc <= acc + beat_sum, beat counter increments (saturating), out_valid unchanged.
REQ-022 Accepted last beat: final = acc + beat_sum + sign-extended psum_in; narrowed to OUT_W per REQ-030/031 into psum_out; out_beats <= count+1 (saturating); out_valid <= 1; acc and counter <= 0 in the same edge.
REQ-023 Latency: result visible the cycle after the accepted last beat; single-beat windows legal.
REQ-024 Two states: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on accepted last beat; FULL->EMPTY on out_ready without accepted last beat; FULL->FULL with new result when out_ready and accepted last beat coincide.
REQ-025 in_ready SHALL equal !out_valid || out_ready (combinational), giving back-to-back windows at full rate.
REQ-026 In FULL with out_ready=0, non-last beats SHALL still be blocked (in_ready=0); psum_out, out_beats, ovf SHALL hold stable.
REQ-027 in_valid with in_ready=0 SHALL not alter any state.
REQ-028 Accumulator overflow within ACC_W SHALL wrap two's-complement; no flag.

Reset
REQ-029 clear=1 at an edge SHALL zero acc, beat counter, psum_out, out_beats, ovf, out_valid, overriding any simultaneous beat or handshake; a partial window in flight is discarded; in_ready=1 the cycle after.

Configuration
REQ-030 With MAC_SAT_EN defined: narrowing SHALL clamp final to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set ovf=1 with that result iff clamping occurred, else ovf=0.
REQ-031 Without MAC_SAT_EN: narrowing SHALL keep the low OUT_W bits; ovf SHALL be constant 0.

Structure
REQ-032 Shared package mac_pkg SHALL hold the EMPTY/FULL state encoding and default values of DATA_W, ACC_W, OUT_W, CNT_W.
REQ-033 Sub-module mac_dot (combinational LANES-wide signed dot product, ACC_W result) SHALL compute beat_sum; all registers live in mac_lane_array.

Verification (LANES=4, DATA_W=8, ACC_W=24, OUT_W=16)
REQ-034 One last beat w={1,2,3,4}, x={5,6,7,8}, psum_in=30 -> next cycle out_valid=1, psum_out=100, out_beats=1.
REQ-035 Three beats all lanes w=-128, x=-128, last with psum_in=0 -> MAC_SAT_EN: psum_out=32767, ovf=1; else psum_out=low 16 bits of 196608=0, ovf=0.
REQ-036 Result pending, out_ready=0 for 5 cycles, in_valid=1 -> in_ready=0, outputs stable; out_ready=1 with last beat -> new result next cycle, no bubble.
REQ-037 Two beats of a window accepted, clear=1 for one cycle, then last beat w=x={1,1,1,1} -> psum_out=4+psum_in, out_beats=1.
REQ-038 Continuous windows of 2 beats with out_ready=1 -> one result every 2 cycles, in_ready constantly 1.
